// File: rtl/faerie_uart.sv
// Memory-mapped 8N1 UART for the Faerie CPU bus: TX FIFO + shifter, optional RX path.
// Define FAERIE_UART_RX_EN to build the receiver, RX FIFO and the overrun/framing flags.
module faerie_uart #(
  parameter logic [15:0] BASE       = 16'hf000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIVL   = 2'd2;
  localparam logic [1:0] OFF_DIVH   = 2'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic        hit;
  logic [1:0]  off;
  logic        wr_data, rd_data, wr_status;
  logic [15:0] div;

  assign hit       = (addr[15:2] == BASE[15:2]);
  assign off       = addr[1:0];
  assign wr_data   = we && hit && (off == OFF_DATA);
  assign rd_data   = re && hit && (off == OFF_DATA);
  assign wr_status = we && hit && (off == OFF_STATUS);

  // Baud divider register, byte-writable
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= DIV_RESET;
    end else if (we && hit) begin
      if (off == OFF_DIVL) div[7:0]  <= wdata;
      if (off == OFF_DIVH) div[15:8] <= wdata;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = wr_data && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // ---------------- TX shifter FSM ----------------
  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_tick, tx_tick_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_tick  <= tx_tick_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx       <= tx_n;
    end
  end

  // Bit counter reloads from div only at boundaries, so divider writes never cut a bit short
  always_comb begin
    tx_state_n = tx_state;
    tx_tick_n  = tx_tick;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    tx_n       = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_mem[tx_rp];
          tx_tick_n  = div;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick == '0) begin
          tx_tick_n  = div;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end else begin
          tx_tick_n = tx_tick - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_tick == '0) begin
          tx_tick_n  = div;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
          else                tx_bit_n   = tx_bit + 3'd1;
        end else begin
          tx_tick_n = tx_tick - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_tick == '0) tx_state_n = TX_IDLE;
        else               tx_tick_n  = tx_tick - 16'd1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
    case (tx_state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = tx_shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

  logic tx_busy;
  assign tx_busy = !tx_empty || (tx_state != TX_IDLE);

  // ---------------- RX path ----------------
  logic       rx_avail, overrun, framing;
  logic [7:0] rx_head;

`ifdef FAERIE_UART_RX_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic rx_s1, rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_push, rx_pop;

  assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_avail = (rx_cnt != '0);
  assign rx_pop   = rd_data && rx_avail;
  assign rx_head  = rx_avail ? rx_mem[rx_rp] : 8'h00;

  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_tick, rx_tick_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        ovr_set, fe_set;
  logic [16:0] rx_half;
  logic [15:0] rx_first;

  // Start bit is sampled (div+1)/2 cycles after the falling edge
  assign rx_half  = (17'(div) + 17'd1) >> 1;
  assign rx_first = (rx_half == '0) ? 16'd0 : 16'(rx_half - 17'd1);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_cnt   <= '0;
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      overrun  <= 1'b0;
      framing  <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      rx_state <= rx_state_n;
      rx_tick  <= rx_tick_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      if (ovr_set)                     overrun <= 1'b1;
      else if (wr_status && wdata[4])  overrun <= 1'b0;
      if (fe_set)                      framing <= 1'b1;
      else if (wr_status && wdata[5])  framing <= 1'b0;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_tick_n  = rx_tick;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    fe_set     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_tick_n  = rx_first;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick == '0) begin
          if (rx_s2) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_tick_n  = div;
            rx_bit_n   = '0;
            rx_state_n = RX_DATA;
          end
        end else begin
          rx_tick_n = rx_tick - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_tick == '0) begin
          rx_tick_n  = div;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_tick_n = rx_tick - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_tick == '0) begin
          if (rx_s2) begin
            rx_state_n = RX_IDLE;
            if (rx_full) ovr_set = 1'b1;
            else         rx_push = 1'b1;
          end else begin
            fe_set     = 1'b1;
            rx_state_n = RX_BREAK;
          end
        end else begin
          rx_tick_n = rx_tick - 16'd1;
        end
      end
      RX_BREAK: begin
        if (rx_s2) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end
`else
  logic unused_rx;
  assign unused_rx = rx ^ wr_status ^ rd_data;
  assign rx_avail  = 1'b0;
  assign overrun   = 1'b0;
  assign framing   = 1'b0;
  assign rx_head   = 8'h00;
`endif

  // Read port: one-cycle latency, zero whenever this window was not read
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'h00;
    end else if (re && hit) begin
      case (off)
        OFF_DATA:   rdata <= rx_head;
        OFF_STATUS: rdata <= {2'b00, framing, overrun, rx_avail, tx_busy, tx_empty, tx_full};
        OFF_DIVL:   rdata <= div[7:0];
        OFF_DIVH:   rdata <= div[15:8];
        default:    rdata <= 8'h00;
      endcase
    end else begin
      rdata <= 8'h00;
    end
  end

endmodule

// File: tb/tb_faerie_uart.sv
// Directed bench for faerie_uart: register map, TX framing, FIFO limits, divider, reset, optional RX.
module tb_faerie_uart;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        tx;
  logic        rx = 1'b1;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] A_DATA   = 16'hf000;
  localparam logic [15:0] A_STATUS = 16'hf001;
  localparam logic [15:0] A_DIVL   = 16'hf002;
  localparam logic [15:0] A_DIVH   = 16'hf003;

  faerie_uart dut (
    .clk   (clk),
    .rst   (rst),
    .re    (re),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    re = 1'b1; addr = a;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  // Decodes one frame at div=3; gap counts idle samples before the start bit
  task automatic tx_capture(output logic [7:0] b, output int gap, output bit ok);
    logic stop;
    gap = 0;
    b = 8'h00;
    ok = 1'b0;
    while (tx !== 1'b0 && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    if (tx === 1'b0) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = tx;
      end
      repeat (4) @(negedge clk);
      stop = tx;
      ok = (stop === 1'b1);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b rdata=%h, required tx=1 rdata=00", tx, rdata);
    end
    rst = 1'b0;
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL reset_status: got %h required 02", d); end
    cpu_read(A_DIVL, d);
    checks++;
    if (d !== 8'h67) begin errors++; $display("FAIL reset_divl: got %h required 67", d); end
    cpu_read(A_DIVH, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_divh: got %h required 00", d); end
    @(negedge clk);
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL rdata_idle: got %h required 00", rdata); end
  endtask

  task automatic test_tx_frame();
    logic [9:0] w;
    logic [7:0] d;
    w = {1'b1, 8'hA5, 1'b0};
    cpu_write(A_DIVL, 8'h03);
    cpu_read(A_DIVL, d);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL divl_rw: got %h required 03", d); end
    cpu_write(A_DATA, 8'hA5);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== w[k/4]) begin
        errors++;
        $display("FAIL tx_a5_sample%0d: tx=%b required %b", k, tx, w[k/4]);
      end
    end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL status_after_frame: got %h required 02", d); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] st;
    logic [7:0] got [5];
    int gaps [5];
    bit oks [5];
    bit line_quiet;
    fork
      begin
        @(negedge clk);
        we = 1'b1; addr = A_DATA;
        for (int i = 0; i < 6; i++) begin
          wdata = 8'(8'h11 * (i + 1));
          @(negedge clk);
        end
        we = 1'b0;
        re = 1'b1; addr = A_STATUS;
        @(negedge clk);
        re = 1'b0;
        st = rdata;
      end
      begin
        for (int f = 0; f < 5; f++) begin
          logic [7:0] b;
          int g;
          bit ok;
          tx_capture(b, g, ok);
          got[f] = b; gaps[f] = g; oks[f] = ok;
        end
      end
    join
    checks++;
    if (st !== 8'h05) begin errors++; $display("FAIL status_full: got %h required 05", st); end
    for (int f = 0; f < 5; f++) begin
      checks++;
      if (!oks[f] || got[f] !== 8'(8'h11 * (f + 1))) begin
        errors++;
        $display("FAIL fifo_byte%0d: got %h ok=%0d required %h", f, got[f], oks[f], 8'(8'h11 * (f + 1)));
      end
      if (f > 0) begin
        checks++;
        if (gaps[f] != 3) begin
          errors++;
          $display("FAIL frame_gap%0d: got %0d samples required 3", f, gaps[f]);
        end
      end
    end
    line_quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) line_quiet = 1'b0;
    end
    checks++;
    if (!line_quiet) begin errors++; $display("FAIL sixth_dropped: tx went low, required idle high"); end
  endtask

  task automatic test_div_zero();
    logic [9:0] w;
    w = {1'b1, 8'h5A, 1'b0};
    cpu_write(A_DIVL, 8'h00);
    cpu_write(A_DATA, 8'h5A);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== w[k]) begin
        errors++;
        $display("FAIL div0_sample%0d: tx=%b required %b", k, tx, w[k]);
      end
    end
    repeat (3) @(negedge clk);
    cpu_write(A_DIVL, 8'h03);
  endtask

  task automatic test_unmapped();
    logic [7:0] d;
    cpu_read(16'h1002, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read: got %h required 00", d); end
`ifndef FAERIE_UART_RX_EN
    cpu_write(A_STATUS, 8'h30);
    cpu_read(A_DATA, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL data_no_rx: got %h required 00", d); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL status_no_rx: got %h required 02", d); end
`endif
  endtask

`ifdef FAERIE_UART_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (4) @(negedge clk);
    end
    rx = stop;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rx();
    logic [7:0] d;
    send_rx(8'h3C, 1'b1);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h0A) begin errors++; $display("FAIL rx_avail: got %h required 0a", d); end
    cpu_read(A_DATA, d);
    checks++;
    if (d !== 8'h3C) begin errors++; $display("FAIL rx_data: got %h required 3c", d); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL rx_drained: got %h required 02", d); end
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h1A) begin errors++; $display("FAIL rx_overrun: got %h required 1a", d); end
    cpu_write(A_STATUS, 8'h10);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h0A) begin errors++; $display("FAIL overrun_clear: got %h required 0a", d); end
    for (int i = 1; i <= 4; i++) begin
      cpu_read(A_DATA, d);
      checks++;
      if (d !== 8'(i)) begin errors++; $display("FAIL rx_fifo%0d: got %h required %h", i, d, 8'(i)); end
    end
    send_rx(8'h77, 1'b0);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h22) begin errors++; $display("FAIL framing: got %h required 22", d); end
    cpu_write(A_STATUS, 8'h20);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL framing_clear: got %h required 02", d); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    bit quiet;
    cpu_write(A_DATA, 8'h00);
    cpu_write(A_DATA, 8'h81);
    cpu_write(A_DATA, 8'h42);
    repeat (6) @(negedge clk);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL status_busy: got %h required 04", d); end
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL tx_mid_frame: tx=%b required 0", tx); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL tx_after_rst: tx=%b required 1", tx); end
    @(negedge clk);
    rst = 1'b0;
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL status_after_rst: got %h required 02", d); end
    cpu_read(A_DIVL, d);
    checks++;
    if (d !== 8'h67) begin errors++; $display("FAIL div_after_rst: got %h required 67", d); end
    cpu_read(16'hf004, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL read_f004: got %h required 00", d); end
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL fifo_flushed: tx went low after reset"); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_fifo_full();
    test_div_zero();
    test_unmapped();
`ifdef FAERIE_UART_RX_EN
    test_rx();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
